// File: rtl/kat_adc3wire_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : kat_adc3wire_scheduler
// Description : Shared 3-wire configuration serializer for two KAT ADCs.
//               Round-robin arbitrates two request ports onto one shift
//               engine and sends {HEADER, addr, data} MSB first to the
//               selected ADC. The other ADC's lines stay idle.
// Revision    : 1.0 - initial release
// ============================================================================
module kat_adc3wire_scheduler #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 8,
    parameter logic [11:0] HEADER     = 12'h001
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst,
    input  logic        req0,
    input  logic [3:0]  addr0,
    input  logic [15:0] data0,
    output logic        ack0,
    output logic        done0,
    input  logic        req1,
    input  logic [3:0]  addr1,
    input  logic [15:0] data1,
    output logic        ack1,
    output logic        done1,
    output logic        busy,
    output logic        adc0_adc3wire_clk,
    output logic        adc0_adc3wire_data,
    output logic        adc0_adc3wire_strobe,
    output logic        adc1_adc3wire_clk,
    output logic        adc1_adc3wire_data,
    output logic        adc1_adc3wire_strobe
);

    localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);
    localparam logic [7:0] c_gap_last = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t      r_state, w_state;
    logic        r_last_grant, w_last_grant;
    logic        r_sel, w_sel;
    logic [30:0] r_shift, w_shift;      // bits still to be sent after the current one
    logic [4:0]  r_bit, w_bit;          // index of the bit currently on the line
    logic [7:0]  r_div, w_div;          // cycle count inside the current half period
    logic [7:0]  r_gap, w_gap;
    logic        r_sclk, w_sclk;
    logic        r_sdata, w_sdata;
    logic        r_strobe, w_strobe;
    logic        w_ack, w_done, w_start;
    logic        w_req_any, w_req_sel;
    logic [31:0] w_frame;

    // Round-robin pick: a lone requester wins, a tie goes away from last_grant
    always_comb begin
        w_req_any = req0 | req1;
        w_req_sel = (req0 && req1) ? ~r_last_grant : req1;
        w_frame   = w_req_sel ? {HEADER, addr1, data1} : {HEADER, addr0, data0};
    end

    // Next-state and next-output logic of the shared shift engine
    always_comb begin
        w_state      = r_state;
        w_last_grant = r_last_grant;
        w_sel        = r_sel;
        w_shift      = r_shift;
        w_bit        = r_bit;
        w_div        = r_div;
        w_gap        = r_gap;
        w_sclk       = r_sclk;
        w_sdata      = r_sdata;
        w_strobe     = r_strobe;
        w_ack        = 1'b0;
        w_done       = 1'b0;
        w_start      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_start = w_req_any;
            end
            ST_SHIFT: begin
                if (r_div == c_div_last) begin
                    w_div = 8'd0;
                    if (!r_sclk) begin
                        w_sclk = 1'b1;
                    end else if (r_bit == 5'd0) begin
                        // End of the high half of bit 0: close the frame
                        w_sclk   = 1'b0;
                        w_sdata  = 1'b0;
                        w_strobe = 1'b1;
                        w_done   = 1'b1;
                        w_bit    = r_bit - 5'd1;
                        w_gap    = 8'd0;
                        w_state  = ST_GAP;
                    end else begin
                        // Falling edge: advance to the next bit
                        w_sclk  = 1'b0;
                        w_bit   = r_bit - 5'd1;
                        w_sdata = r_shift[30];
                        w_shift = {r_shift[29:0], 1'b0};
                    end
                end else begin
                    w_div = r_div + 8'd1;
                end
            end
            ST_GAP: begin
                if (r_gap == c_gap_last) begin
                    // Last gap edge doubles as an arbitration edge
                    w_state = ST_IDLE;
                    w_start = w_req_any;
                end else begin
                    w_gap = r_gap + 8'd1;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        if (w_start) begin
            w_state      = ST_SHIFT;
            w_sel        = w_req_sel;
            w_last_grant = w_req_sel;
            w_sdata      = w_frame[31];
            w_shift      = w_frame[30:0];
            w_strobe     = 1'b0;
            w_sclk       = 1'b0;
            w_div        = 8'd0;
            w_bit        = 5'd31;
            w_ack        = 1'b1;
        end
    end

    // State register plus per-ADC output registers; unselected ADC held idle
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_state              <= ST_IDLE;
            r_last_grant         <= 1'b1;
            r_sel                <= 1'b0;
            r_shift              <= '0;
            r_bit                <= '0;
            r_div                <= '0;
            r_gap                <= '0;
            r_sclk               <= 1'b0;
            r_sdata              <= 1'b0;
            r_strobe             <= 1'b1;
            ack0                 <= 1'b0;
            ack1                 <= 1'b0;
            done0                <= 1'b0;
            done1                <= 1'b0;
            busy                 <= 1'b0;
            adc0_adc3wire_clk    <= 1'b0;
            adc0_adc3wire_data   <= 1'b0;
            adc0_adc3wire_strobe <= 1'b1;
            adc1_adc3wire_clk    <= 1'b0;
            adc1_adc3wire_data   <= 1'b0;
            adc1_adc3wire_strobe <= 1'b1;
        end else begin
            r_state              <= w_state;
            r_last_grant         <= w_last_grant;
            r_sel                <= w_sel;
            r_shift              <= w_shift;
            r_bit                <= w_bit;
            r_div                <= w_div;
            r_gap                <= w_gap;
            r_sclk               <= w_sclk;
            r_sdata              <= w_sdata;
            r_strobe             <= w_strobe;
            ack0                 <= w_ack & ~w_sel;
            ack1                 <= w_ack & w_sel;
            done0                <= w_done & ~w_sel;
            done1                <= w_done & w_sel;
            busy                 <= (w_state != ST_IDLE);
            adc0_adc3wire_clk    <= w_sel ? 1'b0 : w_sclk;
            adc0_adc3wire_data   <= w_sel ? 1'b0 : w_sdata;
            adc0_adc3wire_strobe <= w_sel ? 1'b1 : w_strobe;
            adc1_adc3wire_clk    <= w_sel ? w_sclk   : 1'b0;
            adc1_adc3wire_data   <= w_sel ? w_sdata  : 1'b0;
            adc1_adc3wire_strobe <= w_sel ? w_strobe : 1'b1;
        end
    end

endmodule
`default_nettype wire
